// File: rtl/execute_stage_pipelined.sv
// MIPS EX stage with a registered EX/MEM output and valid/ready handshakes.
// Computes ALU result, zero flag, destination register and branch target.
// Optional feature macro: EXEC_MULT_EN adds an iterative shift-add multiplier
// (funct 011000 with ALUOp=10) that stalls the upstream stage while it runs.
module execute_stage_pipelined #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            iSig_RegDst,
  input  logic [1:0]      iSig_ALUOp,
  input  logic            iSig_ALUSrc,
  input  logic [XLEN-1:0] ipc_plus4,
  input  logic [XLEN-1:0] iregfile_read_1,
  input  logic [XLEN-1:0] iregfile_read_2,
  input  logic [XLEN-1:0] iimm,
  input  logic [REGW-1:0] iins2016,
  input  logic [REGW-1:0] iins1511,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_adder_branch_result,
  output logic [XLEN-1:0] oALU_result,
  output logic            oALU_zero,
  output logic [REGW-1:0] oreg_write_reg,
  output logic            o_busy
);

  logic [5:0]      funct;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [REGW-1:0] wreg_sel;
  logic [XLEN-1:0] br_sel;
  logic            is_mul;
  logic            out_free;
  logic            accept;

  // Output register state
  logic            valid_q;
  logic [XLEN-1:0] res_q;
  logic            zero_q;
  logic [REGW-1:0] wreg_q;
  logic [XLEN-1:0] br_q;

  // Output register load controls
  logic            ld_en;
  logic [XLEN-1:0] ld_res;
  logic [REGW-1:0] ld_wreg;
  logic [XLEN-1:0] ld_br;

  assign funct    = iimm[5:0];
  assign op_b     = iSig_ALUSrc ? iimm : iregfile_read_2;
  assign wreg_sel = iSig_RegDst ? iins1511 : iins2016;
  assign br_sel   = ipc_plus4 + (iimm << 2);
  assign out_free = ~valid_q | i_ready;
  assign accept   = i_valid & o_ready;

  // Single-cycle ALU: ALUOp selects add/sub or defers to the funct field
  always_comb begin
    alu_res = '0;
    unique case (iSig_ALUOp)
      2'b01: alu_res = iregfile_read_1 - op_b;
      2'b10: begin
        unique case (funct)
          6'b100000: alu_res = iregfile_read_1 + op_b;
          6'b100010: alu_res = iregfile_read_1 - op_b;
          6'b100100: alu_res = iregfile_read_1 & op_b;
          6'b100101: alu_res = iregfile_read_1 | op_b;
          6'b101010: alu_res = {{(XLEN-1){1'b0}},
                                ($signed(iregfile_read_1) < $signed(op_b))};
          default:   alu_res = '0;
        endcase
      end
      default: alu_res = iregfile_read_1 + op_b;
    endcase
  end

`ifdef EXEC_MULT_EN
  localparam int unsigned     CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [REGW-1:0] mwreg_q;
  logic [XLEN-1:0] mbr_q;
  logic [XLEN-1:0] acc_next;
  logic            mul_last;
  logic            mul_done;

  assign is_mul   = (iSig_ALUOp == 2'b10) && (funct == 6'b011000);
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (state_q == S_MUL) && (cnt_q == CNT_LAST);
  // The final iteration is deferred until the output register can take it,
  // so the accumulator never advances past the last partial product.
  assign mul_done = mul_last & out_free;
  assign o_ready  = (state_q == S_IDLE) & out_free;
  assign o_busy   = (state_q == S_MUL);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: enter MUL on an accepted multiply, leave when it completes
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (mul_done)         state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shift-add datapath; low XLEN bits of the unsigned product equal the signed one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mwreg_q  <= '0;
      mbr_q    <= '0;
    end else if (accept && is_mul) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= iregfile_read_1;
      mplier_q <= op_b;
      mwreg_q  <= wreg_sel;
      mbr_q    <= br_sel;
    end else if ((state_q == S_MUL) && !(mul_last && !out_free)) begin
      cnt_q    <= cnt_q + 1'b1;
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  // Output load source: a fresh single-cycle result or a finished multiply
  always_comb begin
    ld_en   = accept & ~is_mul;
    ld_res  = alu_res;
    ld_wreg = wreg_sel;
    ld_br   = br_sel;
    if (mul_done) begin
      ld_en   = 1'b1;
      ld_res  = acc_next;
      ld_wreg = mwreg_q;
      ld_br   = mbr_q;
    end
  end
`else
  assign is_mul  = 1'b0;
  assign o_ready = out_free;
  assign o_busy  = 1'b0;

  // Output load source: always the single-cycle result
  always_comb begin
    ld_en   = accept & ~is_mul;
    ld_res  = alu_res;
    ld_wreg = wreg_sel;
    ld_br   = br_sel;
  end
`endif

  // EX/MEM output register: load on new result, clear valid on drain, else hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      wreg_q  <= '0;
      br_q    <= '0;
    end else if (ld_en) begin
      valid_q <= 1'b1;
      res_q   <= ld_res;
      zero_q  <= (ld_res == '0);
      wreg_q  <= ld_wreg;
      br_q    <= ld_br;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid               = valid_q;
  assign oALU_result           = res_q;
  assign oALU_zero             = zero_q;
  assign oreg_write_reg        = wreg_q;
  assign o_adder_branch_result = br_q;

endmodule

// File: tb/tb_execute_stage_pipelined.sv
// Self-checking bench for execute_stage_pipelined: directed cases plus
// randomized traffic scored against a transaction-level reference model.
module tb_execute_stage_pipelined;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic [REGW-1:0] wreg;
    logic [XLEN-1:0] br;
  } exp_t;

  logic            clk;
  logic            rstn;
  logic            i_valid;
  logic            o_ready;
  logic            sRegDst;
  logic [1:0]      sALUOp;
  logic            sALUSrc;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] imm;
  logic [REGW-1:0] rt;
  logic [REGW-1:0] rd;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] br_o;
  logic [XLEN-1:0] res_o;
  logic            zero_o;
  logic [REGW-1:0] wreg_o;
  logic            busy_o;

  int   n_cmp;
  int   n_fail;
  int   n_drained;
  int   mul_cnt;
  exp_t mul_exp;
  exp_t last_out;
  exp_t q[$];

  execute_stage_pipelined #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .i_valid               (i_valid),
    .o_ready               (o_ready),
    .iSig_RegDst           (sRegDst),
    .iSig_ALUOp            (sALUOp),
    .iSig_ALUSrc           (sALUSrc),
    .ipc_plus4             (pc),
    .iregfile_read_1       (rd1),
    .iregfile_read_2       (rd2),
    .iimm                  (imm),
    .iins2016              (rt),
    .iins1511              (rd),
    .o_valid               (o_valid),
    .i_ready               (i_ready),
    .o_adder_branch_result (br_o),
    .oALU_result           (res_o),
    .oALU_zero             (zero_o),
    .oreg_write_reg        (wreg_o),
    .o_busy                (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit is_mul_op(input logic [1:0] op, input logic [XLEN-1:0] im);
`ifdef EXEC_MULT_EN
    return (op == 2'd2) && (im[5:0] == 6'h18);
`else
    return 1'b0;
`endif
  endfunction

  // Reference semantics straight from the instruction set description
  function automatic exp_t ref_exec(input logic [1:0] op, input logic src, input logic dst,
                                    input logic [XLEN-1:0] p, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b, input logic [XLEN-1:0] im,
                                    input logic [REGW-1:0] t, input logic [REGW-1:0] d);
    exp_t e;
    logic [XLEN-1:0] bb;
    logic [XLEN-1:0] r;
    bb = src ? im : b;
    r  = '0;
    if (op == 2'd0 || op == 2'd3)      r = a + bb;
    else if (op == 2'd1)               r = a - bb;
    else if (im[5:0] == 6'h20)         r = a + bb;
    else if (im[5:0] == 6'h22)         r = a - bb;
    else if (im[5:0] == 6'h24)         r = a & bb;
    else if (im[5:0] == 6'h25)         r = a | bb;
    else if (im[5:0] == 6'h2A)         r = ($signed(a) < $signed(bb)) ? 1 : 0;
    else if (is_mul_op(op, im))        r = a * bb;
    e.res  = r;
    e.zero = (r == 0);
    e.wreg = dst ? d : t;
    e.br   = p + im * 4;
    return e;
  endfunction

  // One clock: check outputs against the model, then advance the model on the edge.
  // Entered at a negedge; returns at the next negedge.
  task automatic cycle(output bit accepted);
    exp_t e;
    exp_t cur;
    bit   exp_rdy;
    bit   drn;
    bit   mfree;
    bit   ismul;
    #1;
    exp_rdy = (mul_cnt == 0) && ((q.size() == 0) || i_ready);
    n_cmp++;
    if (o_ready !== exp_rdy) begin
      n_fail++; $display("FAIL o_ready t=%0t got=%b exp=%b", $time, o_ready, exp_rdy);
    end
    n_cmp++;
    if (o_valid !== (q.size() > 0)) begin
      n_fail++; $display("FAIL o_valid t=%0t got=%b exp=%b", $time, o_valid, q.size() > 0);
    end
    n_cmp++;
    if (busy_o !== (mul_cnt > 0)) begin
      n_fail++; $display("FAIL o_busy t=%0t got=%b exp=%b", $time, busy_o, mul_cnt > 0);
    end
    cur = (q.size() > 0) ? q[0] : last_out;
    n_cmp++;
    if (res_o !== cur.res) begin
      n_fail++; $display("FAIL result t=%0t got=%h exp=%h", $time, res_o, cur.res);
    end
    n_cmp++;
    if (zero_o !== cur.zero) begin
      n_fail++; $display("FAIL zero t=%0t got=%b exp=%b", $time, zero_o, cur.zero);
    end
    n_cmp++;
    if (wreg_o !== cur.wreg) begin
      n_fail++; $display("FAIL wreg t=%0t got=%0d exp=%0d", $time, wreg_o, cur.wreg);
    end
    n_cmp++;
    if (br_o !== cur.br) begin
      n_fail++; $display("FAIL branch t=%0t got=%h exp=%h", $time, br_o, cur.br);
    end
    drn      = (q.size() > 0) && i_ready;
    mfree    = (q.size() == 0) || drn;
    accepted = i_valid && exp_rdy;
    ismul    = 1'b0;
    e        = '0;
    if (accepted) begin
      e     = ref_exec(sALUOp, sALUSrc, sRegDst, pc, rd1, rd2, imm, rt, rd);
      ismul = is_mul_op(sALUOp, imm);
    end
    @(posedge clk);
    if (drn) begin
      last_out = q.pop_front();
      n_drained++;
    end
    if (mul_cnt > 1) mul_cnt--;
    else if (mul_cnt == 1 && mfree) begin
      q.push_back(mul_exp);
      mul_cnt = 0;
    end
    if (accepted) begin
      if (ismul) begin
        mul_exp = e;
        mul_cnt = XLEN;
      end else begin
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_op(input logic [1:0] op, input logic src, input logic dst,
                        input logic [XLEN-1:0] p, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] im,
                        input logic [REGW-1:0] t, input logic [REGW-1:0] d);
    sALUOp = op; sALUSrc = src; sRegDst = dst; pc = p;
    rd1 = a; rd2 = b; imm = im; rt = t; rd = d;
  endtask

  task automatic test_reset();
    i_valid = 1'b0;
    i_ready = 1'b1;
    rstn    = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
    n_cmp++; if (busy_o !== 1'b0)  begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    n_cmp++; if (res_o !== '0)     begin n_fail++; $display("FAIL rst_result got=%h exp=0", res_o); end
    n_cmp++; if (zero_o !== 1'b0)  begin n_fail++; $display("FAIL rst_zero got=%b exp=0", zero_o); end
    n_cmp++; if (wreg_o !== '0)    begin n_fail++; $display("FAIL rst_wreg got=%0d exp=0", wreg_o); end
    n_cmp++; if (br_o !== '0)      begin n_fail++; $display("FAIL rst_branch got=%h exp=0", br_o); end
    q.delete();
    mul_cnt  = 0;
    last_out = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    bit acc;
    i_ready = 1'b1;
    // add with immediate -1
    set_op(2'd0, 1'b1, 1'b0, 32'h0, 32'd5, 32'd0, 32'hFFFF_FFFF, 5'd3, 5'd4);
    i_valid = 1'b1; cycle(acc); i_valid = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b1)    begin n_fail++; $display("FAIL add_latency got=%b exp=1", o_valid); end
    n_cmp++; if (res_o !== 32'd4)     begin n_fail++; $display("FAIL add_result got=%h exp=4", res_o); end
    n_cmp++; if (zero_o !== 1'b0)     begin n_fail++; $display("FAIL add_zero got=%b exp=0", zero_o); end
    n_cmp++; if (wreg_o !== 5'd3)     begin n_fail++; $display("FAIL add_wreg got=%0d exp=3", wreg_o); end
    // sub to zero and negative branch offset
    set_op(2'd1, 1'b0, 1'b0, 32'h100, 32'd7, 32'd7, 32'hFFFF_FFFF, 5'd1, 5'd2);
    i_valid = 1'b1; cycle(acc); i_valid = 1'b0;
    #1;
    n_cmp++; if (res_o !== 32'd0)     begin n_fail++; $display("FAIL sub_result got=%h exp=0", res_o); end
    n_cmp++; if (zero_o !== 1'b1)     begin n_fail++; $display("FAIL sub_zero got=%b exp=1", zero_o); end
    n_cmp++; if (br_o !== 32'hFC)     begin n_fail++; $display("FAIL branch_neg got=%h exp=fc", br_o); end
    // signed slt through funct decode, rd destination
    set_op(2'd2, 1'b0, 1'b1, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd6, 5'd9);
    i_valid = 1'b1; cycle(acc); i_valid = 1'b0;
    #1;
    n_cmp++; if (res_o !== 32'd1)     begin n_fail++; $display("FAIL slt_result got=%h exp=1", res_o); end
    n_cmp++; if (wreg_o !== 5'd9)     begin n_fail++; $display("FAIL slt_wreg got=%0d exp=9", wreg_o); end
`ifndef EXEC_MULT_EN
    // multiply funct is unknown when the multiplier is absent
    set_op(2'd2, 1'b0, 1'b0, 32'h0, 32'd3, 32'd6, 32'h18, 5'd2, 5'd5);
    i_valid = 1'b1; cycle(acc); i_valid = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b1)    begin n_fail++; $display("FAIL nomul_latency got=%b exp=1", o_valid); end
    n_cmp++; if (res_o !== 32'd0)     begin n_fail++; $display("FAIL nomul_result got=%h exp=0", res_o); end
`endif
    cycle(acc);
    cycle(acc);
  endtask

  task automatic test_back_to_back();
    bit acc;
    int k;
    int start;
    logic [XLEN-1:0] a_tab [3];
    a_tab[0] = 32'd10; a_tab[1] = 32'd20; a_tab[2] = 32'd30;
    k = 0;
    start = n_drained;
    for (int c = 0; c < 40 && (k < 3 || q.size() > 0); c++) begin
      i_ready = (c >= 5);
      if (k < 3) begin
        set_op(2'd0, 1'b1, 1'b0, 32'h200, a_tab[k], 32'd0, 32'd1, 5'(k + 1), 5'd0);
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      if (c == 3) begin
        #1;
        n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got=%b exp=0", o_ready); end
        n_cmp++; if (res_o !== 32'd11) begin n_fail++; $display("FAIL b2b_hold got=%h exp=b", res_o); end
      end
      cycle(acc);
      if (acc) k++;
    end
    i_valid = 1'b0;
    n_cmp++;
    if (n_drained - start !== 3) begin
      n_fail++; $display("FAIL b2b_count got=%0d exp=3", n_drained - start);
    end
  endtask

`ifdef EXEC_MULT_EN
  task automatic test_mul();
    bit acc;
    int busy_cycles;
    i_ready = 1'b1;
    set_op(2'd2, 1'b0, 1'b1, 32'h1000, 32'hFFFF_FFFD, 32'd6, 32'h18, 5'd1, 5'd12);
    i_valid = 1'b1; cycle(acc); i_valid = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (busy_o !== 1'b1) break;
      busy_cycles++;
      cycle(acc);
    end
    n_cmp++; if (busy_cycles !== 32)         begin n_fail++; $display("FAIL mul_busy got=%0d exp=32", busy_cycles); end
    n_cmp++; if (o_valid !== 1'b1)           begin n_fail++; $display("FAIL mul_valid got=%b exp=1", o_valid); end
    n_cmp++; if (res_o !== 32'hFFFF_FFEE)    begin n_fail++; $display("FAIL mul_result got=%h exp=ffffffee", res_o); end
    n_cmp++; if (wreg_o !== 5'd12)           begin n_fail++; $display("FAIL mul_wreg got=%0d exp=12", wreg_o); end
    cycle(acc);
  endtask
`endif

  task automatic test_random();
    bit acc;
    logic [5:0] fn_tab [7];
    logic [5:0] fn;
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25;
    fn_tab[4] = 6'h2A; fn_tab[5] = 6'h18; fn_tab[6] = 6'h00;
    for (int c = 0; c < 600; c++) begin
      fn = fn_tab[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      set_op(2'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             {26'($urandom), fn}, 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) rd2 = rd1;
      if ($urandom_range(0, 5) == 0) rd1 = 32'($urandom_range(0, 3));
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 80 && (q.size() > 0 || mul_cnt > 0); c++) cycle(acc);
    n_cmp++;
    if (q.size() != 0 || mul_cnt != 0) begin
      n_fail++; $display("FAIL rand_drain_timeout got=%0d pending exp=0", q.size() + mul_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    int c;
    logic [XLEN-1:0] want;
    i_ready = 1'b0;
`ifdef EXEC_MULT_EN
    set_op(2'd2, 1'b0, 1'b0, 32'h0, 32'd9, 32'd9, 32'h18, 5'd4, 5'd0);
`else
    set_op(2'd0, 1'b0, 1'b0, 32'h0, 32'd9, 32'd9, 32'h0, 5'd4, 5'd0);
`endif
    i_valid = 1'b1; cycle(acc); i_valid = 1'b0;
    for (int k = 0; k < 5; k++) cycle(acc);
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", o_valid); end
    n_cmp++; if (busy_o !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
    n_cmp++; if (res_o !== '0)     begin n_fail++; $display("FAIL midrst_result got=%h exp=0", res_o); end
    q.delete();
    mul_cnt  = 0;
    last_out = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    i_ready = 1'b1;
`ifdef EXEC_MULT_EN
    set_op(2'd2, 1'b0, 1'b0, 32'h0, 32'd7, 32'd5, 32'h18, 5'd8, 5'd0);
    want = 32'd35;
`else
    set_op(2'd0, 1'b0, 1'b0, 32'h0, 32'd7, 32'd5, 32'h0, 5'd8, 5'd0);
    want = 32'd12;
`endif
    i_valid = 1'b1; cycle(acc); i_valid = 1'b0;
    i_ready = 1'b0;
    c = 0;
    while (c < 60) begin
      #1;
      if (o_valid === 1'b1) break;
      cycle(acc);
      c++;
    end
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL postrst_timeout got=%b exp=1", o_valid); end
    n_cmp++; if (res_o !== want)   begin n_fail++; $display("FAIL postrst_result got=%h exp=%h", res_o, want); end
    i_ready = 1'b1;
    cycle(acc);
    cycle(acc);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; n_drained = 0; mul_cnt = 0;
    mul_exp = '0; last_out = '0;
    rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    set_op(2'd0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
`ifdef EXEC_MULT_EN
    test_mul();
`endif
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
